// File: rtl/persiana_multicanal.sv
// Multi-channel blind controller: per-channel target/position FSM with a
// shared prescaler, travel timeout, reversal dead time and input synchronisers.
module persiana_multicanal #(
  parameter int N_CH          = 4,
  parameter int PRESCALE_W    = 24,
  parameter int TIMEOUT_TICKS = 16,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reseteo,
  input  logic            ena,
  input  logic            cmd_valid,
  input  logic [CW-1:0]   cmd_ch,
  input  logic [2:0]      cmd,
  input  logic [1:0]      sensor,
  input  logic [N_CH-1:0] s_sup,
  input  logic [N_CH-1:0] s_med,
  input  logic [N_CH-1:0] s_inf,
  output logic [N_CH-1:0] subir,
  output logic [N_CH-1:0] bajar,
  output logic [N_CH-1:0] fault,
  output logic            tick
);

  localparam int TW = $clog2(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    FLT
  } st_t;

  logic [1:0]      sen_m, sen_s;
  logic [N_CH-1:0] sup_m, sup_s;
  logic [N_CH-1:0] med_m, med_s;
  logic [N_CH-1:0] inf_m, inf_s;

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      sen_m <= '0;
      sen_s <= '0;
      sup_m <= '0;
      sup_s <= '0;
      med_m <= '0;
      med_s <= '0;
      inf_m <= '0;
      inf_s <= '0;
    end else begin
      sen_m <= sensor;
      sen_s <= sen_m;
      sup_m <= s_sup;
      sup_s <= sup_m;
      med_m <= s_med;
      med_s <= med_m;
      inf_m <= s_inf;
      inf_s <= inf_m;
    end
  end

  logic [PRESCALE_W-1:0] pre_q;
  logic                  wrap;
  logic                  tick_q;

  assign wrap = &pre_q;
  assign tick = tick_q;

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_q + 1'b1;
      tick_q <= wrap;
    end
  end

  logic cmd_ok;

  assign cmd_ok = cmd_valid & ena
                & (int'(cmd_ch) < N_CH)
                & (cmd <= 3'b100);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [2:0]    tgt_q;
    st_t           st_q;
    logic [TW-1:0] to_q;
    logic          up_q, dn_q, flt_q;
    logic [1:0]    eff, pos;
    logic          sel, known, hit, bad;
    logic          go_up, go_dn, dn_rev;

    assign sel = cmd_ok & (int'(cmd_ch) == c);

    // Levels: 0 none/between, 1 bottom, 2 middle, 3 top
    assign eff = (tgt_q == 3'b100) ? sen_s : tgt_q[1:0];
    assign pos = sup_s[c] ? 2'd3 :
                 med_s[c] ? 2'd2 :
                 inf_s[c] ? 2'd1 : 2'd0;

    assign known = (pos != 2'd0);
    assign hit   = known & (eff == pos);
    assign bad   = sup_s[c] & inf_s[c];

    assign go_up  = (eff != 2'd0)
                  & (known ? (eff > pos) : (eff != 2'd1));
    assign go_dn  = (eff != 2'd0)
                  & (known ? (eff < pos) : (eff == 2'd1));
    // Heading down between sensors toward MID is not a reversal
    assign dn_rev = (eff != 2'd0)
                  & (known ? (eff > pos) : (eff == 2'd3));

    always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
        tgt_q <= '0;
        st_q  <= IDLE;
        to_q  <= '0;
        up_q  <= 1'b0;
        dn_q  <= 1'b0;
        flt_q <= 1'b0;
      end else begin
        if (sel) tgt_q <= cmd;
        up_q  <= (st_q == UP) & ena;
        dn_q  <= (st_q == DOWN) & ena;
        flt_q <= (st_q == FLT);
        if (sel && cmd == 3'b000 && st_q == FLT) begin
          st_q <= IDLE;
          to_q <= '0;
        end else if (wrap && ena) begin
          if (bad) begin
            st_q <= FLT;
          end else begin
            unique case (st_q)
              IDLE: begin
                to_q <= '0;
                if (go_up)      st_q <= UP;
                else if (go_dn) st_q <= DOWN;
              end
              UP: begin
                if (eff == 2'd0 || hit || go_dn)
                  st_q <= IDLE;
                else if (to_q == TW'(TIMEOUT_TICKS - 1))
                  st_q <= FLT;
                else
                  to_q <= to_q + 1'b1;
              end
              DOWN: begin
                if (eff == 2'd0 || hit || dn_rev)
                  st_q <= IDLE;
                else if (to_q == TW'(TIMEOUT_TICKS - 1))
                  st_q <= FLT;
                else
                  to_q <= to_q + 1'b1;
              end
              FLT: ;
              default: st_q <= FLT;
            endcase
          end
        end
      end
    end

    assign subir[c] = up_q;
    assign bajar[c] = dn_q;
    assign fault[c] = flt_q;
  end

endmodule
